multi_debouncer: RTL and testbench

- Parametrised N-channel successor to the single-button debouncer.
- Each channel synchronises a raw button or switch input, then debounces it symmetrically so both press and release must be stable.
- Each channel emits one-cycle rise and fall edge pulses, plus an optional hold/auto-repeat pulse train.
- Sits between the board buttons and the game-control FSM, which consumes only the pulse outputs.

---
 rtl/game_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/multi_debouncer.sv | 36 +++
 tb/tb_multi_debouncer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default timing for the board-input front end.
// Defaults assume a 100 MHz clock: 10 ms debounce, 500 ms hold, 100 ms repeat.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int CLK_HZ             = 100_000_000;
  localparam int DEF_STABLE_CYCLES  = CLK_HZ / 100;
  localparam int DEF_HOLD_CYCLES    = CLK_HZ / 2;
  localparam int DEF_REPEAT_CYCLES  = CLK_HZ / 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, symmetric stability counter,
// registered edge pulses and a hold/auto-repeat FSM driven by the clean level.
module debounce_channel
  import game_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int HMAX = max_int(max_int(HOLD_CYCLES, REPEAT_CYCLES), 1);
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);
  localparam logic [HW-1:0] R_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          flip, rise_n, fall_n;

  rpt_state_e    state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          rpt_n;

  assign sync   = sync_q[1];
  // The level flips on the edge where the STABLE_CYCLES-th consecutive mismatch is seen.
  assign flip   = (sync != clean) && (cnt == S_LAST);
  assign rise_n = flip & ~clean;
  assign fall_n = flip &  clean;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], noisy};
      if (sync != clean && !flip) cnt <= cnt + CW'(1);
      else                        cnt <= '0;
      if (flip) clean <= ~clean;
      rise <= rise_n;
      fall <= fall_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      rpt   <= rpt_n;
    end
  end

  // Fall wins over a due repeat pulse so the release cycle is always quiet.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt + HW'(1);
    rpt_n   = 1'b0;
    case (state)
      IDLE: begin
        hcnt_n = '0;
        if (rise_n) state_n = HOLD;
      end
      HOLD: begin
        if (fall_n) begin
          state_n = IDLE;
          hcnt_n  = '0;
        end else if (hcnt == H_LAST) begin
          state_n = REPEAT;
          hcnt_n  = '0;
          rpt_n   = 1'b1;
        end
      end
      REPEAT: begin
        if (fall_n) begin
          state_n = IDLE;
          hcnt_n  = '0;
        end else if (hcnt == R_LAST) begin
          hcnt_n  = '0;
          rpt_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        hcnt_n  = '0;
      end
    endcase
    if (HOLD_CYCLES == 0) begin
      state_n = IDLE;
      hcnt_n  = '0;
      rpt_n   = 1'b0;
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// N independent button channels, each synchronised, debounced and turned
// into rise/fall/repeat pulses for the game-control FSM.
module multi_debouncer
  import game_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .noisy (noisy_in[i]),
      .clean (clean_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i]),
      .rpt   (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed scenarios plus random button noise, checked every cycle against
// a window/arithmetic reference model of the debounce and repeat rules.
module tb_multi_debouncer;

  localparam int NCH = 2;
  localparam int STB = 4;
  localparam int HLD = 10;
  localparam int RPT = 3;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] noisy_in;
  logic [NCH-1:0] clean_out, rise_pulse, fall_pulse, repeat_pulse;

  int total = 0;
  int bad   = 0;

  multi_debouncer #(
    .N_CH(NCH), .STABLE_CYCLES(STB), .HOLD_CYCLES(HLD), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .noisy_in     (noisy_in),
    .clean_out    (clean_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs delayed two edges (zeros after reset), a level
  // flips after STB consecutive mismatching observations, repeats fall at
  // HLD + n*RPT cycles after the rise while the level stays high.
  logic [NCH-1:0] dl[$];
  logic [NCH-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_rep = '0;
  int run[NCH];
  int rise_at[NCH];
  int cyc = 0;

  always @(posedge clk) begin
    logic [NCH-1:0] obs;
    int d;
    cyc++;
    m_rise = '0; m_fall = '0; m_rep = '0;
    if (rst) begin
      dl = {NCH'(0), NCH'(0)};
      m_clean = '0;
      for (int c = 0; c < NCH; c++) run[c] = 0;
    end else begin
      obs = dl[0];
      dl.push_back(noisy_in);
      void'(dl.pop_front());
      for (int c = 0; c < NCH; c++) begin
        if (obs[c] != m_clean[c]) run[c]++;
        else                      run[c] = 0;
        if (run[c] == STB) begin
          run[c] = 0;
          m_clean[c] = ~m_clean[c];
          if (m_clean[c]) begin
            m_rise[c] = 1'b1;
            rise_at[c] = cyc;
          end else begin
            m_fall[c] = 1'b1;
          end
        end else if (m_clean[c]) begin
          d = cyc - rise_at[c];
          if (d >= HLD && (d - HLD) % RPT == 0) m_rep[c] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_clean", 32'(clean_out),    32'(m_clean));
    chk("m_rise",  32'(rise_pulse),   32'(m_rise));
    chk("m_fall",  32'(fall_pulse),   32'(m_fall));
    chk("m_rep",   32'(repeat_pulse), 32'(m_rep));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    noisy_in = '0;
    rst      = 1'b1;
    step(3);

    // reset with inputs held high
    noisy_in = 2'b11;
    step(2);
    chk("rst_clean", 32'(clean_out), 0);
    chk("rst_rise",  32'(rise_pulse), 0);
    chk("rst_rep",   32'(repeat_pulse), 0);
    rst = 1'b0;
    step(5);
    chk("rel_clean5", 32'(clean_out), 0);
    step(1);
    chk("rel_clean6", 32'(clean_out), 2'b11);
    chk("rel_rise6",  32'(rise_pulse), 2'b11);
    noisy_in = 2'b00;
    step(20);

    // clean press on ch0, held into repeat, then released
    noisy_in = 2'b01;
    step(5);
    chk("press_early", 32'(clean_out), 0);
    step(1);
    chk("press_clean", 32'(clean_out), 2'b01);
    chk("press_rise",  32'(rise_pulse), 2'b01);
    step(1);
    chk("press_rise_off", 32'(rise_pulse), 0);
    step(9);
    chk("rep_r10", 32'(repeat_pulse), 2'b01);
    step(2);
    chk("rep_r12", 32'(repeat_pulse), 0);
    step(1);
    chk("rep_r13", 32'(repeat_pulse), 2'b01);
    step(3);
    chk("rep_r16", 32'(repeat_pulse), 2'b01);
    noisy_in = 2'b00;
    step(6);
    chk("fall_pulse", 32'(fall_pulse), 2'b01);
    chk("fall_norep", 32'(repeat_pulse), 0);
    step(1);
    chk("fall_off", 32'(fall_pulse), 0);
    step(10);

    // glitches shorter than the stability window
    noisy_in = 2'b01; step(3);
    noisy_in = 2'b00; step(10);
    chk("glitch1", 32'(clean_out), 0);
    noisy_in = 2'b01; step(3);
    noisy_in = 2'b00; step(1);
    noisy_in = 2'b01; step(3);
    noisy_in = 2'b00; step(10);
    chk("glitch2", 32'(clean_out), 0);

    // simultaneous press, ch1 released while ch0 holds
    noisy_in = 2'b11;
    step(6);
    chk("sim_rise", 32'(rise_pulse), 2'b11);
    step(4);
    noisy_in = 2'b01;
    step(6);
    chk("sim_fall", 32'(fall_pulse), 2'b10);
    chk("sim_rep",  32'(repeat_pulse), 2'b01);

    // reset while ch0 is repeating
    step(4);
    rst = 1'b1;
    step(1);
    chk("mid_clean", 32'(clean_out), 0);
    chk("mid_fall",  32'(fall_pulse), 0);
    chk("mid_rep",   32'(repeat_pulse), 0);
    rst = 1'b0;
    step(6);
    chk("mid_rise", 32'(rise_pulse), 2'b01);
    step(9);
    chk("mid_rep9", 32'(repeat_pulse), 0);
    step(1);
    chk("mid_rep10", 32'(repeat_pulse), 2'b01);
    noisy_in = 2'b00;
    step(20);

    // random noise with varying toggle rates and occasional resets
    for (int seg = 0; seg < 12; seg++) begin
      int rate;
      rate = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 6 : 2);
      for (int t = 0; t < 250; t++) begin
        logic [NCH-1:0] nv;
        nv = noisy_in;
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 99) < rate) nv[c] = ~nv[c];
        noisy_in = nv;
        rst = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    rst = 1'b0;
    noisy_in = '0;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
